nzaa_fc_seq: RTL

- Hardware sequencer that drives the nzaa accumulator's input protocol for one fully-connected layer.
- Streams N_IN activation/weight pairs per output row from on-chip memories.
- Frames each row with clear / last_line / wr, then captures the nzaa 256-bit result into a ready/valid result port.
- Replaces the bench-driven stimulus when the FC layer runs in silicon.

---
 rtl/nzaa_pkg.sv | 21 ++
 rtl/nzaa_addr_gen.sv | 78 +++++++
 rtl/nzaa_fc_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nzaa_pkg.sv
// Shared types and constants for the nzaa fully-connected layer sequencer.
package nzaa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_LAST,
    S_DRAIN,
    S_WR,
    S_CAP,
    S_HOLD
  } state_e;

  localparam int NZAA_DW        = 16;
  localparam int NZAA_WW        = 256;
  localparam int NZAA_THW       = 5;
  localparam int NZAA_N_IN_DEF  = 4096;
  localparam int NZAA_N_ROW_DEF = 63;

endpackage

// File: rtl/nzaa_addr_gen.sv
// Element/row counters and memory address generation for the FC sequencer.
// Addresses are driven combinationally while issuing and held from a register otherwise.
module nzaa_addr_gen #(
  parameter int N_IN  = 4096,
  parameter int N_ROW = 63,
  parameter int XAW   = 12,
  parameter int WAW   = 18,
  parameter int RW    = 6
) (
  input  logic           clk_h,
  input  logic           rst_n,
  input  logic           init,
  input  logic           clr,
  input  logic           step,
  input  logic           next_row,
  output logic [XAW-1:0] x_addr,
  output logic [WAW-1:0] w_addr,
  output logic [RW-1:0]  row,
  output logic           last_k,
  output logic           last_row
);

  logic [XAW-1:0] k_q, k_d;
  logic [XAW-1:0] xa_q, x_cur;
  logic [WAW-1:0] w_base_q, w_base_d;
  logic [WAW-1:0] wa_q, w_cur;
  logic [RW-1:0]  row_q, row_d;

  assign last_k   = (k_q == XAW'(N_IN - 1));
  assign last_row = (row_q == RW'(N_ROW - 1));
  assign x_addr   = x_cur;
  assign w_addr   = w_cur;
  assign row      = row_q;

  always_comb begin
    k_d      = k_q;
    row_d    = row_q;
    w_base_d = w_base_q;
    x_cur    = xa_q;
    w_cur    = wa_q;
    if (init) begin
      row_d    = '0;
      w_base_d = '0;
    end
    if (clr) begin
      k_d   = '0;
      x_cur = '0;
      w_cur = w_base_q;
    end
    // On the final element the address holds so nothing past the row is read.
    if (step && !last_k) begin
      k_d   = k_q + XAW'(1);
      x_cur = k_q + XAW'(1);
      w_cur = w_base_q + WAW'(k_q) + WAW'(1);
    end
    if (next_row) begin
      row_d    = row_q + RW'(1);
      w_base_d = w_base_q + WAW'(N_IN);
    end
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      row_q    <= '0;
      w_base_q <= '0;
      xa_q     <= '0;
      wa_q     <= '0;
    end else begin
      k_q      <= k_d;
      row_q    <= row_d;
      w_base_q <= w_base_d;
      xa_q     <= x_cur;
      wa_q     <= w_cur;
    end
  end

endmodule

// File: rtl/nzaa_fc_seq.sv
// Drives the nzaa accumulator for one FC layer: frames each row with clear/last_line/wr
// and hands each captured 256-bit result to a ready/valid port.
module nzaa_fc_seq
  import nzaa_pkg::*;
#(
  parameter int DW    = NZAA_DW,
  parameter int WW    = NZAA_WW,
  parameter int N_IN  = NZAA_N_IN_DEF,
  parameter int N_ROW = NZAA_N_ROW_DEF,
  parameter int XAW   = 12,
  parameter int WAW   = 18,
  parameter int RW    = 6,
  parameter int DRAIN = 2
) (
  input  logic                clk_h,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NZAA_THW-1:0] th_cfg,
  output logic                busy,
  output logic                done,
  output logic [XAW-1:0]      x_addr,
  input  logic [DW-1:0]       x_rdata,
  output logic [WAW-1:0]      w_addr,
  input  logic [WW-1:0]       w_rdata,
  output logic                clear,
  output logic [NZAA_THW-1:0] th,
  output logic [DW-1:0]       data_in,
  output logic [WW-1:0]       weight_in,
  output logic                last_line,
  output logic                wr,
  input  logic [WW-1:0]       acc_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RW-1:0]       res_row,
  output logic [WW-1:0]       res_data
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_e              state_q, state_d;
  logic [NZAA_THW-1:0] th_q, th_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                res_valid_q, res_valid_d;
  logic [RW-1:0]       res_row_q, res_row_d;
  logic [WW-1:0]       res_data_q, res_data_d;
  logic [DCW-1:0]      drain_q, drain_d;

  logic          ag_init, ag_clr, ag_step, ag_next;
  logic          last_k, last_row;
  logic [RW-1:0] row;

  nzaa_addr_gen #(
    .N_IN  (N_IN),
    .N_ROW (N_ROW),
    .XAW   (XAW),
    .WAW   (WAW),
    .RW    (RW)
  ) u_addr_gen (
    .clk_h    (clk_h),
    .rst_n    (rst_n),
    .init     (ag_init),
    .clr      (ag_clr),
    .step     (ag_step),
    .next_row (ag_next),
    .x_addr   (x_addr),
    .w_addr   (w_addr),
    .row      (row),
    .last_k   (last_k),
    .last_row (last_row)
  );

  assign data_in   = x_rdata;
  assign weight_in = w_rdata;
  assign th        = th_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_row   = res_row_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    th_d        = th_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_row_d   = res_row_q;
    res_data_d  = res_data_q;
    drain_d     = drain_q;
    clear       = 1'b0;
    last_line   = 1'b0;
    wr          = 1'b0;
    ag_init     = 1'b0;
    ag_clr      = 1'b0;
    ag_step     = 1'b0;
    ag_next     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          th_d    = th_cfg;
          busy_d  = 1'b1;
          ag_init = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        clear   = 1'b1;
        ag_clr  = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        ag_step = 1'b1;
        if (last_k) state_d = S_LAST;
      end
      S_LAST: begin
        last_line = 1'b1;
        drain_d   = '0;
        state_d   = (DRAIN == 0) ? S_WR : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DCW'(DRAIN - 1)) state_d = S_WR;
        else                            drain_d = drain_q + DCW'(1);
      end
      S_WR: begin
        wr      = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        res_data_d  = acc_out;
        res_row_d   = row;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (last_row) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ag_next = 1'b1;
            state_d = S_CLR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      th_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_data_q  <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      th_q        <= th_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_data_q  <= res_data_d;
      drain_q     <= drain_d;
    end
  end

endmodule
